// File: rtl/am_mod_gen.sv
// AM modulator: DDS carrier (phase accumulator + sine ROM), debounced step keys,
// 4-stage DSB / AM / carrier / bypass datapath with offset-binary output.
module am_mod_gen #(
  parameter int DW         = 8,
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 10,
  parameter int MI_W       = 8,
  parameter int FW_MIN     = 4096,
  parameter int FW_STEP    = 4096,
  parameter int NSTEPS     = 64,
  parameter int INIT_IDX   = 0,
  parameter int DEB_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_add,
  input  logic                 key_sub,
  input  logic [1:0]           mode,
  input  logic [MI_W-1:0]      ma,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] data_in,
  output logic                 out_valid,
  output logic [DW-1:0]        mod_wave,
  output logic [5:0]           freq_idx
);

  typedef enum logic [1:0] {
    MODE_DSB = 2'b00,
    MODE_AM  = 2'b01,
    MODE_CAR = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  localparam int IDX_W  = 6;
  localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
  localparam int E_W    = DW + MI_W + 2;
  localparam int P_W    = E_W + DW;
  localparam int C_MAX  = 2 ** (DW - 1) - 1;
  localparam real PI    = 3.14159265358979323846;

  localparam logic [PHASE_W-1:0]    FW_MIN_V  = PHASE_W'(FW_MIN);
  localparam logic [PHASE_W-1:0]    FW_STEP_V = PHASE_W'(FW_STEP);
  localparam logic [IDX_W-1:0]      IDX_INIT  = IDX_W'(INIT_IDX);
  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NSTEPS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [DW-1:0]         MIDSCALE  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [E_W-1:0] E_BIAS    = E_W'(C_MAX);
  localparam logic signed [P_W-1:0] P_MAX     = P_W'(C_MAX);
  localparam logic signed [P_W-1:0] P_MIN     = -P_MAX - P_W'(1);

  // Rounded to nearest, symmetric about zero, so the most negative code never appears.
  function automatic logic signed [DW-1:0] sine_entry(input int k);
    real a;
    real r;
    a = (2.0 ** (DW - 1) - 1.0) * $sin(2.0 * PI * k / (2.0 ** LUT_AW));
    r = (a >= 0.0) ? $floor(a + 0.5) : $ceil(a - 0.5);
    return DW'($rtoi(r));
  endfunction

  // NOTE: the sine table is a constant, not storage, so it needs no reset.
  logic signed [DW-1:0] sine_rom [2**LUT_AW];
  for (genvar k = 0; k < 2 ** LUT_AW; k++) begin : g_rom
    localparam logic signed [DW-1:0] ENTRY = sine_entry(k);
    assign sine_rom[k] = ENTRY;
  end

  // Key path: index 0 is add, index 1 is sub.
  logic [1:0]            key_raw;
  logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d, pulse_q, pulse_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      freq_idx_q, freq_idx_d;
  logic [PHASE_W-1:0]    fw_q, fw_d, phase_q, phase_d;

  // Datapath pipeline.
  logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DW-1:0]  x1_q, x1_d, x2_q, x2_d;
  mode_e                 mode1_q, mode1_d, mode2_q, mode2_d;
  logic [MI_W-1:0]       ma1_q, ma1_d;
  logic [LUT_AW-1:0]     pidx1_q, pidx1_d;
  logic signed [DW-1:0]  c2_q, c2_d;
  logic signed [E_W-1:0] e2_q, e2_d;
  logic signed [P_W-1:0] p3_q, p3_d;
  logic                  out_valid_q, out_valid_d;
  logic [DW-1:0]         mod_wave_q, mod_wave_d;

  logic signed [E_W-1:0] ma_ext, x_ext;
  logic signed [P_W-1:0] px_ext, pc_ext, pe_ext;
  logic signed [DW-1:0]  sat;

  assign key_raw = {key_sub, key_add};

  always_comb begin
    // NOTE: every _d and temporary gets a default first so no latch is inferred.
    sync1_d     = key_raw;
    sync2_d     = sync1_q;
    deb_d       = deb_q;
    cnt_d       = cnt_q;
    pulse_d     = '0;
    freq_idx_d  = freq_idx_q;
    fw_d        = FW_MIN_V + PHASE_W'(freq_idx_q) * FW_STEP_V;
    phase_d     = phase_q;
    v1_d        = in_valid;
    x1_d        = x1_q;
    mode1_d     = mode1_q;
    ma1_d       = ma1_q;
    pidx1_d     = pidx1_q;
    v2_d        = v1_q;
    x2_d        = x1_q;
    mode2_d     = mode1_q;
    c2_d        = sine_rom[pidx1_q];
    ma_ext      = E_W'($signed({1'b0, ma1_q}));
    x_ext       = E_W'(x1_q);
    e2_d        = E_BIAS + ((ma_ext * x_ext) >>> MI_W);
    v3_d        = v2_q;
    px_ext      = P_W'(x2_q);
    pc_ext      = P_W'(c2_q);
    pe_ext      = P_W'(e2_q);
    p3_d        = '0;
    out_valid_d = v3_q;
    mod_wave_d  = mod_wave_q;
    sat         = '0;

    // A change is taken only after DEB_CYCLES consecutive differing samples.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i]   = sync2_q[i];
          cnt_d[i]   = '0;
          pulse_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    case (pulse_q)
      2'b01:   if (freq_idx_q != IDX_MAX) freq_idx_d = freq_idx_q + IDX_W'(1);
      2'b10:   if (freq_idx_q != '0)      freq_idx_d = freq_idx_q - IDX_W'(1);
      default: freq_idx_d = freq_idx_q;
    endcase

    // The sample latches the phase before its own increment.
    if (in_valid) begin
      phase_d = phase_q + fw_q;
      x1_d    = data_in;
      mode1_d = mode_e'(mode);
      ma1_d   = ma;
      pidx1_d = phase_q[PHASE_W-1 -: LUT_AW];
    end

    case (mode2_q)
      MODE_DSB: p3_d = (px_ext * pc_ext) >>> (DW - 1);
      MODE_AM:  p3_d = (pe_ext * pc_ext) >>> (DW - 1);
      MODE_CAR: p3_d = pc_ext;
      default:  p3_d = px_ext;
    endcase

    if (p3_q > P_MAX)      sat = DW'(P_MAX);
    else if (p3_q < P_MIN) sat = DW'(P_MIN);
    else                   sat = p3_q[DW-1:0];
    if (v3_q) mod_wave_d = {~sat[DW-1], sat[DW-2:0]};
  end

  // NOTE: state updates use <= so every flop samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      cnt_q       <= '0;
      pulse_q     <= '0;
      freq_idx_q  <= IDX_INIT;
      fw_q        <= FW_MIN_V + PHASE_W'(IDX_INIT) * FW_STEP_V;
      phase_q     <= '0;
      v1_q        <= 1'b0;
      x1_q        <= '0;
      mode1_q     <= MODE_DSB;
      ma1_q       <= '0;
      pidx1_q     <= '0;
      v2_q        <= 1'b0;
      x2_q        <= '0;
      mode2_q     <= MODE_DSB;
      c2_q        <= '0;
      e2_q        <= '0;
      v3_q        <= 1'b0;
      p3_q        <= '0;
      out_valid_q <= 1'b0;
      mod_wave_q  <= MIDSCALE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      freq_idx_q  <= freq_idx_d;
      fw_q        <= fw_d;
      phase_q     <= phase_d;
      v1_q        <= v1_d;
      x1_q        <= x1_d;
      mode1_q     <= mode1_d;
      ma1_q       <= ma1_d;
      pidx1_q     <= pidx1_d;
      v2_q        <= v2_d;
      x2_q        <= x2_d;
      mode2_q     <= mode2_d;
      c2_q        <= c2_d;
      e2_q        <= e2_d;
      v3_q        <= v3_d;
      p3_q        <= p3_d;
      out_valid_q <= out_valid_d;
      mod_wave_q  <= mod_wave_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mod_wave  = mod_wave_q;
  assign freq_idx  = freq_idx_q;

endmodule

// File: tb/tb_am_mod_gen.sv
// Directed bench for am_mod_gen: carrier fixed at fw=2^22 so consecutive samples
// see c = 0, 127, 0, -127; keys debounced over 4 clocks.
module tb_am_mod_gen;

  localparam logic [1:0] M_DSB = 2'b00;
  localparam logic [1:0] M_AM  = 2'b01;
  localparam logic [1:0] M_CAR = 2'b10;
  localparam logic [1:0] M_BYP = 2'b11;
  localparam int N_VEC = 24;

  typedef struct packed {
    logic [1:0]        mode;
    logic [7:0]        ma;
    logic signed [7:0] x;
    logic [7:0]        exp_wave;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_add, key_sub;
  logic [1:0]        mode;
  logic [7:0]        ma;
  logic              in_valid;
  logic signed [7:0] data_in;
  logic              out_valid;
  logic [7:0]        mod_wave;
  logic [5:0]        freq_idx;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs [N_VEC];

  am_mod_gen #(
    .DW(8), .PHASE_W(24), .LUT_AW(10), .MI_W(8),
    .FW_MIN(4194304), .FW_STEP(0), .NSTEPS(64), .INIT_IDX(0), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .key_add(key_add), .key_sub(key_sub),
    .mode(mode), .ma(ma), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .mod_wave(mod_wave), .freq_idx(freq_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic add, input logic sub, input int hold);
    key_add = add;
    key_sub = sub;
    repeat (hold) tick();
    key_add = 1'b0;
    key_sub = 1'b0;
    repeat (14) tick();
  endtask

  initial begin
    logic [7:0] post_exp [2];

    // Carrier per sample slot: 0, 127, 0, -127.
    vecs[0]  = '{M_CAR, 8'd0,   8'sd0,    8'd128};
    vecs[1]  = '{M_CAR, 8'd0,   8'sd0,    8'd255};
    vecs[2]  = '{M_CAR, 8'd0,   8'sd0,    8'd128};
    vecs[3]  = '{M_CAR, 8'd0,   8'sd0,    8'd1};
    vecs[4]  = '{M_DSB, 8'd0,   8'sd50,   8'd128};
    vecs[5]  = '{M_DSB, 8'd0,   8'sd127,  8'd254};
    vecs[6]  = '{M_BYP, 8'd0,   8'h80,    8'd0};
    vecs[7]  = '{M_DSB, 8'd0,   8'h80,    8'd255};
    vecs[8]  = '{M_AM,  8'd128, 8'sd127,  8'd128};
    vecs[9]  = '{M_AM,  8'd128, 8'sd127,  8'd255};
    vecs[10] = '{M_BYP, 8'd0,   8'sd5,    8'd133};
    vecs[11] = '{M_DSB, 8'd0,   8'sd127,  8'd1};
    vecs[12] = '{M_CAR, 8'd0,   8'sd0,    8'd128};
    vecs[13] = '{M_AM,  8'd128, 8'h80,    8'd190};
    vecs[14] = '{M_BYP, 8'd0,   8'sd100,  8'd228};
    vecs[15] = '{M_AM,  8'd0,   8'sd77,   8'd1};
    vecs[16] = '{M_DSB, 8'd0,   -8'sd1,   8'd128};
    vecs[17] = '{M_AM,  8'd0,   -8'sd99,  8'd254};
    vecs[18] = '{M_DSB, 8'd0,   8'sd1,    8'd128};
    vecs[19] = '{M_BYP, 8'd0,   -8'sd7,   8'd121};
    vecs[20] = '{M_DSB, 8'd0,   8'sd100,  8'd128};
    vecs[21] = '{M_BYP, 8'd0,   8'sd127,  8'd255};
    vecs[22] = '{M_DSB, 8'd0,   8'h80,    8'd128};
    vecs[23] = '{M_AM,  8'd128, 8'sd127,  8'd0};
    post_exp[0] = 8'd128;
    post_exp[1] = 8'd255;

    rst = 1'b0; key_add = 1'b0; key_sub = 1'b0;
    mode = M_DSB; ma = 8'd0; in_valid = 1'b1; data_in = 8'sd99;

    // Reset held with in_valid active.
    repeat (3) begin
      tick();
      check("reset_wave", int'(mod_wave), 128);
      check("reset_valid", int'(out_valid), 0);
    end
    check("reset_idx", int'(freq_idx), 0);

    // Back-to-back stream starting on the reset release edge.
    for (int t = 0; t < N_VEC + 3; t++) begin
      if (t == 0) rst = 1'b1;
      if (t < N_VEC) begin
        in_valid = 1'b1;
        mode     = vecs[t].mode;
        ma       = vecs[t].ma;
        data_in  = vecs[t].x;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (t >= 3) begin
        check($sformatf("vec%0d_valid", t - 3), int'(out_valid), 1);
        check($sformatf("vec%0d_wave", t - 3), int'(mod_wave), int'(vecs[t-3].exp_wave));
      end else begin
        check("latency_valid", int'(out_valid), 0);
      end
    end

    // Output holds once valid drops.
    repeat (3) begin
      tick();
      check("hold_valid", int'(out_valid), 0);
      check("hold_wave", int'(mod_wave), int'(vecs[N_VEC-1].exp_wave));
    end

    // Reset in the middle of a stream discards in-flight samples and the phase.
    mode = M_CAR; in_valid = 1'b1; data_in = 8'sd0;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      tick();
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_wave", int'(mod_wave), 128);
    end
    rst = 1'b1;
    repeat (5) begin
      tick();
      check("flush_valid", int'(out_valid), 0);
    end
    for (int t = 0; t < 5; t++) begin
      in_valid = (t < 2);
      tick();
      if (t >= 3) begin
        check("post_valid", int'(out_valid), 1);
        check("post_wave", int'(mod_wave), int'(post_exp[t-3]));
      end else begin
        check("post_latency", int'(out_valid), 0);
      end
    end
    in_valid = 1'b0;

    // Keys.
    press(1'b1, 1'b0, 3);
    check("key_short", int'(freq_idx), 0);
    press(1'b1, 1'b0, 20);
    check("key_add_once", int'(freq_idx), 1);
    press(1'b1, 1'b0, 4);
    check("key_add_min_hold", int'(freq_idx), 2);
    for (int i = 0; i < 61; i++) press(1'b1, 1'b0, 6);
    check("key_add_top", int'(freq_idx), 63);
    press(1'b1, 1'b0, 20);
    check("key_add_sat", int'(freq_idx), 63);
    press(1'b0, 1'b1, 20);
    check("key_sub_once", int'(freq_idx), 62);
    press(1'b1, 1'b1, 20);
    check("key_both", int'(freq_idx), 62);
    for (int i = 0; i < 62; i++) press(1'b0, 1'b1, 6);
    check("key_sub_bottom", int'(freq_idx), 0);
    press(1'b0, 1'b1, 20);
    check("key_sub_sat", int'(freq_idx), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
